// File: rtl/jtag_pkg.sv
// Shared constants and types for the JTAG instruction register and DR muxing.
package jtag_pkg;

  // Default opcodes for a 5-bit IR. BYPASS is all-ones at whatever width is used.
  localparam logic [4:0] IdcodeOpDef = 5'h01;
  localparam logic [4:0] DtmcsOpDef  = 5'h10;
  localparam logic [4:0] DmiOpDef    = 5'h11;
  localparam logic [4:0] BypassOpDef = 5'h1f;

  // Low two bits of every Capture-IR pattern; bit0 = 1 is required by IEEE 1149.1.
  localparam logic [1:0] IrCaptureLsb = 2'b01;

  // One-hot data-register select. All-zero means the opcode was not recognised.
  typedef struct packed {
    logic idcode;
    logic dtmcs;
    logic dmi;
    logic bypass;
  } ir_sel_t;

  localparam ir_sel_t SelIdcode = '{idcode: 1'b1, default: 1'b0};
  localparam ir_sel_t SelBypass = '{bypass: 1'b1, default: 1'b0};

endpackage

// File: rtl/jtag_ir_decode.sv
// Combinational opcode decoder: one-hot DR select; an all-zero result marks an
// unknown opcode. Shared by the IR controller and the DR mux.
module jtag_ir_decode
  import jtag_pkg::*;
#(
  parameter int unsigned           IR_WIDTH  = 5,
  parameter logic [IR_WIDTH-1:0]   IDCODE_OP = IR_WIDTH'(IdcodeOpDef),
  parameter logic [IR_WIDTH-1:0]   DTMCS_OP  = IR_WIDTH'(DtmcsOpDef),
  parameter logic [IR_WIDTH-1:0]   DMI_OP    = IR_WIDTH'(DmiOpDef),
  parameter logic [IR_WIDTH-1:0]   BYPASS_OP = '1
) (
  input  logic [IR_WIDTH-1:0] op,
  output ir_sel_t             sel
);

  // Straight equality compares; opcodes are distinct so at most one bit is set.
  always_comb begin
    sel        = '0;
    sel.idcode = (op == IDCODE_OP);
    sel.dtmcs  = (op == DTMCS_OP);
    sel.dmi    = (op == DMI_OP);
    sel.bypass = (op == BYPASS_OP);
  end

endmodule

// File: rtl/jtag_ir_ctrl.sv
// JTAG instruction register: serial shift path, length/opcode checked update,
// sticky error flags reported via Capture-IR, registered one-hot DR selects.
// Optional feature: define JTAG_IR_LOCK_EN to add dbg_lock, which blocks
// DTMCS/DMI access by forcing BYPASS.
module jtag_ir_ctrl
  import jtag_pkg::*;
#(
  parameter int unsigned           IR_WIDTH  = 5,
  parameter logic [IR_WIDTH-1:0]   IDCODE_OP = IR_WIDTH'(IdcodeOpDef),
  parameter logic [IR_WIDTH-1:0]   DTMCS_OP  = IR_WIDTH'(DtmcsOpDef),
  parameter logic [IR_WIDTH-1:0]   DMI_OP    = IR_WIDTH'(DmiOpDef),
  parameter logic [IR_WIDTH-1:0]   BYPASS_OP = '1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tap_reset,
  input  logic                tdi,
  output logic                tdo,
  input  logic                capture_ir,
  input  logic                shift_ir,
  input  logic                update_ir,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic                sel_idcode,
  output logic                sel_dtmcs,
  output logic                sel_dmi,
  output logic                sel_bypass,
  output logic                err_len,
  output logic                err_illegal
`ifdef JTAG_IR_LOCK_EN
  ,
  input  logic                dbg_lock
`endif
);

  localparam int unsigned CntW = $clog2(IR_WIDTH + 2);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t CntFull = cnt_t'(IR_WIDTH);
  localparam cnt_t CntMax  = cnt_t'(IR_WIDTH + 1);

  logic [IR_WIDTH-1:0] shift_q, shift_d;
  logic [IR_WIDTH-1:0] latch_q, latch_d;
  cnt_t                cnt_q, cnt_d;
  logic                armed_q, armed_d;
  logic                err_len_q, err_len_d;
  logic                err_ill_q, err_ill_d;
  ir_sel_t             sel_q, sel_d;
  ir_sel_t             shift_sel, latch_sel;
  logic                lock_active;
  logic                accept;

`ifdef JTAG_IR_LOCK_EN
  assign lock_active = dbg_lock;
`else
  assign lock_active = 1'b0;
`endif

  jtag_ir_decode #(
    .IR_WIDTH  (IR_WIDTH),
    .IDCODE_OP (IDCODE_OP),
    .DTMCS_OP  (DTMCS_OP),
    .DMI_OP    (DMI_OP),
    .BYPASS_OP (BYPASS_OP)
  ) u_shift_decode (
    .op  (shift_q),
    .sel (shift_sel)
  );

  jtag_ir_decode #(
    .IR_WIDTH  (IR_WIDTH),
    .IDCODE_OP (IDCODE_OP),
    .DTMCS_OP  (DTMCS_OP),
    .DMI_OP    (DMI_OP),
    .BYPASS_OP (BYPASS_OP)
  ) u_latch_decode (
    .op  (latch_d),
    .sel (latch_sel)
  );

  // Opcode is accepted if known, and not a debug-access opcode while locked.
  assign accept = shift_sel.idcode | shift_sel.bypass |
                  ((shift_sel.dtmcs | shift_sel.dmi) & ~lock_active);

  // Next-state: one strobe acts per edge, tap_reset > capture > shift > update.
  always_comb begin
    shift_d   = shift_q;
    latch_d   = latch_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    err_len_d = err_len_q;
    err_ill_d = err_ill_q;
    if (tap_reset) begin
      shift_d   = IDCODE_OP;
      latch_d   = IDCODE_OP;
      cnt_d     = '0;
      armed_d   = 1'b0;
      err_len_d = 1'b0;
      err_ill_d = 1'b0;
    end else if (capture_ir) begin
      // Flags are handed to the shift path and cleared in the same edge.
      shift_d      = '0;
      shift_d[3]   = err_ill_q;
      shift_d[2]   = err_len_q;
      shift_d[1:0] = IrCaptureLsb;
      cnt_d        = '0;
      armed_d      = 1'b1;
      err_len_d    = 1'b0;
      err_ill_d    = 1'b0;
    end else if (shift_ir) begin
      shift_d = {tdi, shift_q[IR_WIDTH-1:1]};
      if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
    end else if (update_ir && armed_q) begin
      armed_d = 1'b0;
      if (cnt_q != CntFull) begin
        err_len_d = 1'b1;
      end else if (accept) begin
        latch_d = shift_q;
      end else begin
        latch_d   = BYPASS_OP;
        err_ill_d = 1'b1;
      end
    end
    // Lock asserted while a debug-access instruction is held evicts it.
    if (!tap_reset && lock_active && (latch_d == latch_q) &&
        ((latch_q == DTMCS_OP) || (latch_q == DMI_OP))) begin
      latch_d = BYPASS_OP;
    end
  end

  // Selects follow the next latch value; anything unrecognised selects BYPASS.
  always_comb begin
    sel_d = latch_sel;
    if (latch_sel == '0) sel_d = SelBypass;
  end

  // State registers with asynchronous reset to the IDCODE instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= IDCODE_OP;
      latch_q   <= IDCODE_OP;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      err_len_q <= 1'b0;
      err_ill_q <= 1'b0;
      sel_q     <= SelIdcode;
    end else begin
      shift_q   <= shift_d;
      latch_q   <= latch_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      err_len_q <= err_len_d;
      err_ill_q <= err_ill_d;
      sel_q     <= sel_d;
    end
  end

  assign tdo         = shift_q[0];
  assign ir_out      = latch_q;
  assign sel_idcode  = sel_q.idcode;
  assign sel_dtmcs   = sel_q.dtmcs;
  assign sel_dmi     = sel_q.dmi;
  assign sel_bypass  = sel_q.bypass;
  assign err_len     = err_len_q;
  assign err_illegal = err_ill_q;

endmodule

// File: tb/tb_jtag_ir_ctrl.sv
// Directed bench for jtag_ir_ctrl at IR_WIDTH=5. Define JTAG_IR_LOCK_EN to
// also exercise the debug lock.
module tb_jtag_ir_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tap_reset;
  logic       tdi;
  logic       tdo;
  logic       capture_ir;
  logic       shift_ir;
  logic       update_ir;
  logic [4:0] ir_out;
  logic       sel_idcode;
  logic       sel_dtmcs;
  logic       sel_dmi;
  logic       sel_bypass;
  logic       err_len;
  logic       err_illegal;
`ifdef JTAG_IR_LOCK_EN
  logic       dbg_lock;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtag_ir_ctrl #(
    .IR_WIDTH (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tap_reset   (tap_reset),
    .tdi         (tdi),
    .tdo         (tdo),
    .capture_ir  (capture_ir),
    .shift_ir    (shift_ir),
    .update_ir   (update_ir),
    .ir_out      (ir_out),
    .sel_idcode  (sel_idcode),
    .sel_dtmcs   (sel_dtmcs),
    .sel_dmi     (sel_dmi),
    .sel_bypass  (sel_bypass),
    .err_len     (err_len),
    .err_illegal (err_illegal)
`ifdef JTAG_IR_LOCK_EN
    ,
    .dbg_lock    (dbg_lock)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive strobes for one edge; outputs are sampled 1 time unit after it.
  task automatic cyc(input logic cap, input logic sh, input logic upd, input logic d,
                     input logic tr);
    capture_ir = cap;
    shift_ir   = sh;
    update_ir  = upd;
    tdi        = d;
    tap_reset  = tr;
    @(posedge clk);
    #1;
    capture_ir = 1'b0;
    shift_ir   = 1'b0;
    update_ir  = 1'b0;
    tdi        = 1'b0;
    tap_reset  = 1'b0;
  endtask

  // Shift n bits of v LSB-first, checking tdo before each edge against exp_tdo.
  task automatic shift_chk(input string tag, input logic [4:0] v, input int n,
                           input logic [4:0] exp_tdo);
    for (int i = 0; i < n; i++) begin
      chk(tag, {31'd0, tdo}, {31'd0, exp_tdo[i]});
      cyc(1'b0, 1'b1, 1'b0, v[i], 1'b0);
    end
  endtask

  task automatic shift_bits(input logic [4:0] v, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, v[i], 1'b0);
  endtask

  task automatic chk_sel(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, sel_idcode, sel_dtmcs, sel_dmi, sel_bypass}, {28'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    tap_reset = 1'b0; tdi = 1'b0;
    capture_ir = 1'b0; shift_ir = 1'b0; update_ir = 1'b0;
`ifdef JTAG_IR_LOCK_EN
    dbg_lock = 1'b0;
`endif
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_ir", ir_out, 5'h01);
    chk_sel("rst_sel", 4'b1000);
    chk("rst_tdo", tdo, 1'b1);
    chk("rst_err_len", err_len, 1'b0);
    chk("rst_err_ill", err_illegal, 1'b0);

    // Legal update to DMI; captured pattern 00001 emerges as 1,0,0,0,0
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_chk("legal_tdo", 5'h11, 5, 5'b00001);
    chk("legal_ir_stable", ir_out, 5'h01);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("legal_ir", ir_out, 5'h11);
    chk_sel("legal_sel", 4'b0010);

    // Short shift: 4 bits only
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_bits(5'h00, 4);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("short_ir", ir_out, 5'h11);
    chk("short_err_len", err_len, 1'b1);
    chk_sel("short_sel", 4'b0010);

    // Capture reports 00101 and clears the flag; shift in illegal 5'h07
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cap_clr_len", err_len, 1'b0);
    shift_chk("short_pat", 5'h07, 5, 5'b00101);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ill_ir", ir_out, 5'h1f);
    chk_sel("ill_sel", 4'b0001);
    chk("ill_err", err_illegal, 1'b1);
    chk("ill_err_len", err_len, 1'b0);

    // Next capture pattern 01001; load 5'h10 along the way
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cap_clr_ill", err_illegal, 1'b0);
    shift_chk("ill_pat", 5'h10, 5, 5'b01001);

    // Capture and update together: capture wins, so 5'h10 never latches
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("prio_ir", ir_out, 5'h1f);
    chk("prio_tdo", tdo, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("prio_len_err", err_len, 1'b1);
    chk("prio_ir2", ir_out, 5'h1f);

    // Counter saturates past IR_WIDTH: 7 shifts is still a length error
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_bits(5'h11, 5);
    shift_bits(5'h00, 2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sat_err_len", err_len, 1'b1);
    chk("sat_ir", ir_out, 5'h1f);

    // tap_reset mid-shift, then a full shift without capture: update ignored
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_bits(5'h11, 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("trst_ir", ir_out, 5'h01);
    chk_sel("trst_sel", 4'b1000);
    chk("trst_tdo", tdo, 1'b1);
    chk("trst_err_len", err_len, 1'b0);
    shift_bits(5'h11, 5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("trst_upd_ign", ir_out, 5'h01);
    chk("trst_upd_len", err_len, 1'b0);

    // Tap reset beats a simultaneous capture
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    shift_bits(5'h11, 5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("trst_cap_ir", ir_out, 5'h01);

`ifdef JTAG_IR_LOCK_EN
    // Locked: DTMCS resolves to BYPASS with err_illegal
    dbg_lock = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_bits(5'h10, 5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lock_ir", ir_out, 5'h1f);
    chk("lock_err", err_illegal, 1'b1);
    // Unlocked: DTMCS latches
    dbg_lock = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_bits(5'h10, 5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("unlock_ir", ir_out, 5'h10);
    chk_sel("unlock_sel", 4'b0100);
    // Lock asserted while DTMCS is held evicts it on the next edge
    dbg_lock = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("evict_ir", ir_out, 5'h1f);
    chk_sel("evict_sel", 4'b0001);
    dbg_lock = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
